// File: rtl/dma_bus_master.sv
// Word-copy DMA engine acting as a bus initiator.
// Configured through a small MMIO register file; copies LEN words SRC -> DST.
module dma_bus_master #(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        irq
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_SRC    = 8'h10;
  localparam logic [7:0] A_DST    = 8'h11;
  localparam logic [7:0] A_LEN    = 8'h12;
  localparam logic [7:0] A_REMAIN = 8'h13;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]          src_reg;
  logic [31:0]          dst_reg;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [31:0]          buffer;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] remain;
  logic                 done_q;
  logic                 error_q;
  logic                 abort_q;
  logic [TW-1:0]        tcount;

  logic cfg_wr;
  logic start;
  logic abort_req;
  logic hs;
  logic tout;
  logic fail_exit;

  assign cfg_wr    = cs & we;
  assign start     = cfg_wr & (address == A_CTRL)
                   & write_data[0] & (state == IDLE);
  assign abort_req = cfg_wr & (address == A_CTRL)
                   & write_data[1] & busy;
  assign hs        = mem_valid & mem_ready;
  assign tout      = mem_valid & ~mem_ready
                   & (tcount == TW'(TIMEOUT_CYCLES - 1));
  // A latched abort only bites once the pending handshake completes.
  assign fail_exit = (hs & abort_q) | tout;

  assign mem_instr = 1'b0;
  assign irq       = done_q | error_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len_reg == '0) ? DONE : READ;
      end
      READ: begin
        if (fail_exit) state_nx = IDLE;
        else if (hs)   state_nx = WRITE;
      end
      WRITE: begin
        if (fail_exit)
          state_nx = IDLE;
        else if (hs)
          state_nx = (remain == LEN_WIDTH'(1)) ? DONE : READ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (state)
      READ: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = src_ptr;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = buffer;
        mem_wstrb = 4'hf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      tcount <= '0;
    else if (!busy || state_nx != state)
      tcount <= '0;
    else
      tcount <= tcount + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      remain  <= '0;
      buffer  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
      ready   <= 1'b0;
    end else begin
      ready <= cs;
      if (cfg_wr && !busy) begin
        if (address == A_SRC) src_reg <= {write_data[31:2], 2'b00};
        if (address == A_DST) dst_reg <= {write_data[31:2], 2'b00};
        if (address == A_LEN) len_reg <= write_data[LEN_WIDTH-1:0];
      end
      if (start) begin
        src_ptr <= src_reg;
        dst_ptr <= dst_reg;
        remain  <= len_reg;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if (abort_req) abort_q <= 1'b1;
      if (hs && state == READ) buffer <= mem_rdata;
      if (hs && state == WRITE) begin
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        remain  <= remain - LEN_WIDTH'(1);
      end
      if (state == DONE) done_q <= 1'b1;
      if (fail_exit) begin
        error_q <= 1'b1;
        done_q  <= 1'b0;
      end
      if (state_nx == IDLE) abort_q <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    case (address)
      A_STATUS: read_data = {29'b0, error_q, done_q, busy};
      A_SRC:    read_data = src_reg;
      A_DST:    read_data = dst_reg;
      A_LEN:    read_data = 32'(len_reg);
      A_REMAIN: read_data = 32'(remain);
      default:  read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Randomized bench for dma_bus_master with a sparse-memory responder
// and a transaction-level copy model.
module tb_dma_bus_master;

  localparam int TO = 16;

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_SRC    = 8'h10;
  localparam logic [7:0] A_DST    = 8'h11;
  localparam logic [7:0] A_LEN    = 8'h12;
  localparam logic [7:0] A_REMAIN = 8'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        irq;

  dma_bus_master #(
    .LEN_WIDTH(16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .we(we),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy(busy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] mem[bit [31:0]];
  logic [31:0] mm[bit [31:0]];

  int lat = 1;
  int wcnt = 0;
  int vcount = 0;
  int viol = 0;

  logic        pv = 1'b0;
  logic [31:0] pa;
  logic [31:0] pd;
  logic [3:0]  ps;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  // Responder: ready after `lat` sampled valid cycles; lat==0 never answers.
  always @(posedge clk) begin
    if (mem_ready) begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end else if (mem_valid && lat != 0) begin
      if (wcnt + 1 >= lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= rd(mem_addr);
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (mem_valid) vcount++;
    if (mem_valid && mem_addr[1:0] != 2'b00) viol++;
    if (mem_instr !== 1'b0) viol++;
    if (mem_valid && mem_wstrb != 4'h0 && mem_wstrb != 4'hf) viol++;
    if (pv && mem_valid &&
        (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps))
      viol++;
    pv = mem_valid && !mem_ready;
    pa = mem_addr;
    pd = mem_wdata;
    ps = mem_wstrb;
    if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'hf) begin
        log_q.push_back({1'b1, mem_addr, mem_wdata});
        mem[mem_addr] = mem_wdata;
      end else begin
        log_q.push_back({1'b0, mem_addr, mem_rdata});
      end
    end
  end

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1;
    we = 1'b1;
    address = a;
    write_data = d;
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    cs = 1'b1;
    we = 1'b0;
    address = a;
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int bcyc);
    bcyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (irq) return;
      if (busy) bcyc++;
      @(negedge clk);
    end
    check("irq_wait", {31'b0, irq}, 32'd1);
  endtask

  // Reference: sequential word copy over a snapshot of memory.
  task automatic build_expected(input logic [31:0] s0,
                                input logic [31:0] d0,
                                input int n);
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] w;
    mm = mem;
    exp_q.delete();
    s = s0 & ~32'h3;
    d = d0 & ~32'h3;
    for (int i = 0; i < n; i++) begin
      w = mm.exists(s) ? mm[s] : dflt(s);
      exp_q.push_back({1'b0, s, w});
      exp_q.push_back({1'b1, d, w});
      mm[d] = w;
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_ntxn"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i),
            {31'b0, log_q[i].w}, {31'b0, exp_q[i].w});
      check($sformatf("%s_a%0d", tag, i), log_q[i].a, exp_q[i].a);
      check($sformatf("%s_d%0d", tag, i), log_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic run_copy(input string tag, input logic [31:0] s,
                          input logic [31:0] d, input int n,
                          input int l, input logic [31:0] ctrl);
    int bc;
    logic [31:0] r;
    lat = l;
    cfg_write(A_SRC, s);
    cfg_write(A_DST, d);
    cfg_write(A_LEN, n);
    build_expected(s, d, n);
    log_q.delete();
    vcount = 0;
    cfg_write(A_CTRL, ctrl);
    wait_irq(n * 2 * (l + 2) + 20, bc);
    check({tag, "_busy_cyc"}, bc, n * 2 * (l + 1));
    check({tag, "_irq"}, {31'b0, irq}, 32'd1);
    cfg_read(A_STATUS, r);
    check({tag, "_status"}, r, 32'd2);
    cfg_read(A_REMAIN, r);
    check({tag, "_remain"}, r, 32'd0);
    compare_log(tag);
  endtask

  logic [31:0] r;
  int          bc;
  int          ok;

  initial begin
    reset = 1'b1;
    cs = 1'b0;
    we = 1'b0;
    address = '0;
    write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    reset = 1'b0;
    cfg_read(A_STATUS, r);
    check("rst_status", r, 32'd0);
    check("cfg_ready", {31'b0, ready}, 32'd1);
    cfg_read(A_SRC, r);
    check("rst_src", r, 32'd0);

    // Register access rules
    cfg_write(A_SRC, 32'h4000_0003);
    cfg_read(A_SRC, r);
    check("src_align", r, 32'h4000_0000);
    cfg_write(A_LEN, 32'habcd_1234);
    cfg_read(A_LEN, r);
    check("len_mask", r, 32'h0000_1234);
    cfg_write(8'h55, 32'hdead_beef);
    cfg_read(8'h55, r);
    check("unmapped", r, 32'd0);
    cfg_write(A_CTRL, 32'd2);
    cfg_read(A_STATUS, r);
    check("abort_idle", r, 32'd0);

    // Directed 3-word copy
    mem[32'h4000_0000] = 32'h1111_1111;
    mem[32'h4000_0004] = 32'h2222_2222;
    mem[32'h4000_0008] = 32'h3333_3333;
    run_copy("copy3", 32'h4000_0000, 32'h4000_1000, 3, 1, 32'd1);
    check("copy3_mem2", rd(32'h4000_1008), 32'h3333_3333);

    // Zero-length start
    lat = 1;
    cfg_write(A_LEN, 32'd0);
    log_q.delete();
    vcount = 0;
    cfg_write(A_CTRL, 32'd1);
    wait_irq(2, bc);
    check("len0_valid", vcount, 0);
    cfg_read(A_STATUS, r);
    check("len0_status", r, 32'd2);

    // Start and abort together: start wins
    run_copy("startwin", 32'h0000_8000, 32'h0000_9000, 1, 1, 32'd3);

    // Pointer wrap
    run_copy("wrap", 32'hffff_fffc, 32'h0000_0200, 2, 2, 32'd1);
    if (log_q.size() > 2) check("wrap_rd2", log_q[2].a, 32'h0);
    else check("wrap_size", log_q.size(), 4);

    // Timeout with a silent responder
    lat = 0;
    cfg_write(A_SRC, 32'h0000_1000);
    cfg_write(A_LEN, 32'd2);
    log_q.delete();
    vcount = 0;
    cfg_write(A_CTRL, 32'd1);
    wait_irq(40, bc);
    check("to_valid_cyc", vcount, TO);
    check("to_busy", {31'b0, busy}, 32'd0);
    check("to_valid", {31'b0, mem_valid}, 32'd0);
    cfg_read(A_STATUS, r);
    check("to_status", r, 32'd4);
    cfg_read(A_REMAIN, r);
    check("to_remain", r, 32'd2);
    check("to_ntxn", log_q.size(), 0);

    // Abort during the first write of a 4-word copy
    lat = 5;
    cfg_write(A_SRC, 32'h0000_3000);
    cfg_write(A_DST, 32'h0000_4000);
    cfg_write(A_LEN, 32'd4);
    build_expected(32'h0000_3000, 32'h0000_4000, 1);
    log_q.delete();
    cfg_write(A_CTRL, 32'd1);
    ok = 0;
    for (int i = 0; i < 50 && ok == 0; i++) begin
      if (mem_valid && mem_wstrb == 4'hf) ok = 1;
      else @(negedge clk);
    end
    check("abort_saw_write", ok, 1);
    cfg_write(A_CTRL, 32'd2);
    wait_irq(60, bc);
    repeat (10) @(negedge clk);
    cfg_read(A_STATUS, r);
    check("abort_status", r, 32'd4);
    cfg_read(A_REMAIN, r);
    check("abort_remain", r, 32'd3);
    compare_log("abort");

    // Writes and start while busy are ignored
    lat = 3;
    cfg_write(A_SRC, 32'h0000_5000);
    cfg_write(A_DST, 32'h0000_6000);
    cfg_write(A_LEN, 32'd3);
    build_expected(32'h0000_5000, 32'h0000_6000, 3);
    log_q.delete();
    cfg_write(A_CTRL, 32'd1);
    cfg_write(A_SRC, 32'h0000_7000);
    cfg_write(A_LEN, 32'd9);
    cfg_write(A_CTRL, 32'd1);
    wait_irq(60, bc);
    repeat (5) @(negedge clk);
    cfg_read(A_SRC, r);
    check("busy_src", r, 32'h0000_5000);
    cfg_read(A_LEN, r);
    check("busy_len", r, 32'd3);
    compare_log("busywr");

    // Randomized copies
    for (int k = 0; k < 6; k++) begin
      run_copy($sformatf("rnd%0d", k), $urandom(), $urandom(),
               $urandom_range(1, 6), $urandom_range(1, 4), 32'd1);
    end

    // Reset in the middle of a transfer
    lat = 0;
    cfg_write(A_SRC, 32'h0000_2000);
    cfg_write(A_LEN, 32'd2);
    cfg_write(A_CTRL, 32'd1);
    repeat (3) @(negedge clk);
    check("mid_valid_pre", {31'b0, mem_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_valid", {31'b0, mem_valid}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    cfg_read(A_SRC, r);
    check("mid_src", r, 32'd0);
    cfg_read(A_STATUS, r);
    check("mid_status", r, 32'd0);

    check("bus_protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
